// File: rtl/module_keypad_scan.sv
// 4x4 keypad scanner: one debounced key code per press, paced by rising edges of prd_in.
// Acts 2 clk after a prd_in edge; key_valid is a 1-clk pulse with no backpressure (consumer must take it).
module module_keypad_scan #(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       prd_in,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_PRESSED} state_t;

  state_t        state;
  logic [3:0]    col_s1, col_s2;
  logic          prd_d, tick_r;
  logic [1:0]    row_idx;
  logic [3:0]    cand;
  logic [CW-1:0] cnt, rcnt;
  logic          hit;
  logic [1:0]    col_idx;
  logic          cand_col_high;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1 <= 4'hF;
      col_s2 <= 4'hF;
      prd_d  <= 1'b1;
      tick_r <= 1'b0;
    end else begin
      col_s1 <= col_in;
      col_s2 <= col_s1;
      prd_d  <= prd_in;
      tick_r <= prd_in & ~prd_d;
    end
  end

  // Lowest-index low column wins when several are pressed together.
  always_comb begin
    hit     = ~&col_s2;
    col_idx = 2'd3;
    if (!col_s2[2]) col_idx = 2'd2;
    if (!col_s2[1]) col_idx = 2'd1;
    if (!col_s2[0]) col_idx = 2'd0;
    cand_col_high = col_s2[cand[1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SCAN;
      row_idx   <= 2'd0;
      row_out   <= 4'b1110;
      cand      <= 4'h0;
      cnt       <= '0;
      rcnt      <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick_r) begin
        case (state)
          ST_SCAN: begin
            if (hit) begin
              cand <= {row_idx, col_idx};
              rcnt <= '0;
              if (DEBOUNCE == 1) begin
                key_code  <= {row_idx, col_idx};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                cnt       <= '0;
                state     <= ST_PRESSED;
              end else begin
                cnt   <= CW'(1);
                state <= ST_DEBOUNCE;
              end
            end else begin
              row_idx <= row_idx + 2'd1;
              row_out <= {row_out[2:0], row_out[3]};
            end
          end
          ST_DEBOUNCE: begin
            if (hit && col_idx == cand[1:0]) begin
              if (cnt == LAST) begin
                key_code  <= cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                cnt       <= '0;
                rcnt      <= '0;
                state     <= ST_PRESSED;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end else begin
              cnt     <= '0;
              state   <= ST_SCAN;
              row_idx <= row_idx + 2'd1;
              row_out <= {row_out[2:0], row_out[3]};
            end
          end
          ST_PRESSED: begin
            // Only the accepted key's column matters here; other keys are ignored.
            if (cand_col_high) begin
              if (rcnt == LAST) begin
                key_held <= 1'b0;
                rcnt     <= '0;
                state    <= ST_SCAN;
                row_idx  <= row_idx + 2'd1;
                row_out  <= {row_out[2:0], row_out[3]};
              end else begin
                rcnt <= rcnt + CW'(1);
              end
            end else begin
              rcnt <= '0;
            end
          end
          default: state <= ST_SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_module_keypad_scan.sv
// Directed bench for module_keypad_scan with a behavioural 4x4 keypad model.
module tb_module_keypad_scan;

  logic        clk;
  logic        rst;
  logic        prd_in;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] keys;       // bit {r,c} set when key (r,c) is down
  bit          prd_hold;
  int          n_tests;
  int          n_fail;
  int          vld_cnt;
  logic [3:0]  vld_code;

  module_keypad_scan #(.DEBOUNCE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .prd_in    (prd_in),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 10-clk divisor waveform; prd_hold freezes it at its current level.
  initial begin
    prd_in = 1'b0;
    @(negedge clk);
    prd_in = 1'b1;
    forever begin
      repeat (5) @(negedge clk);
      if (!prd_hold) prd_in = ~prd_in;
    end
  end

  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      vld_cnt  = vld_cnt + 1;
      vld_code = key_code;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns 4 clk after a prd_in rising edge, well after the DUT has acted on it.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge prd_in);
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic wait_row(input logic [3:0] r);
    int n;
    n = 0;
    while (row_out !== r && n < 8) begin
      tick(1);
      n++;
    end
    chk("align_row", row_out, r);
  endtask

  task automatic release_rst();
    @(negedge prd_in);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] idle_rows [8];
    bit         frozen;
    idle_rows = '{4'b1101, 4'b1011, 4'b0111, 4'b1110,
                  4'b1101, 4'b1011, 4'b0111, 4'b1110};
    n_tests  = 0;
    n_fail   = 0;
    vld_cnt  = 0;
    vld_code = 4'h0;
    keys     = '0;
    prd_hold = 1'b0;
    rst      = 1'b1;

    // Reset: outputs held at reset values while prd_in moves.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_outputs", {row_out, key_code, key_valid, key_held}, {4'b1110, 4'h0, 1'b0, 1'b0});
    end
    release_rst();
    @(negedge clk);
    chk("post_rst_outputs", {row_out, key_code, key_valid, key_held}, {4'b1110, 4'h0, 1'b0, 1'b0});

    // Idle scan: one row step per tick.
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk($sformatf("idle_row%0d", i), row_out, idle_rows[i]);
    end
    chk("idle_no_valid", vld_cnt, 0);

    // Clean press of (2,1): accepted on the 4th tick that sees it.
    wait_row(4'b1011);
    keys[9] = 1'b1;
    tick(3);
    chk("press_t3_valid", vld_cnt, 0);
    chk("press_t3_held", key_held, 1'b0);
    tick(1);
    chk("press_valid_cnt", vld_cnt, 1);
    chk("press_vld_code", vld_code, 4'h9);
    chk("press_code", key_code, 4'h9);
    chk("press_held", key_held, 1'b1);
    frozen = 1'b1;
    repeat (16) begin
      tick(1);
      if (row_out !== 4'b1011) frozen = 1'b0;
    end
    chk("held_row_frozen", frozen, 1'b1);
    chk("held_single_valid", vld_cnt, 1);
    keys = '0;
    tick(3);
    chk("release_t3_held", key_held, 1'b1);
    tick(1);
    chk("release_t4_held", key_held, 1'b0);
    chk("release_row", row_out, 4'b0111);

    // Bounce on (1,3): never reaches four matching ticks.
    wait_row(4'b1101);
    keys[7] = 1'b1;
    tick(2);
    keys = '0;
    tick(1);
    keys[7] = 1'b1;
    tick(2);
    keys = '0;
    tick(1);
    chk("bounce_no_valid", vld_cnt, 1);
    chk("bounce_code", key_code, 4'h9);
    chk("bounce_held", key_held, 1'b0);
    chk("bounce_row", row_out, 4'b1101);

    // Columns 1 and 3 together on row 0: lowest column wins.
    wait_row(4'b1110);
    keys[1] = 1'b1;
    keys[3] = 1'b1;
    tick(6);
    chk("multi_valid_cnt", vld_cnt, 2);
    chk("multi_code", key_code, 4'h1);
    chk("multi_held", key_held, 1'b1);
    chk("multi_row", row_out, 4'b1110);
    keys = '0;
    tick(4);
    chk("multi_release_held", key_held, 1'b0);
    chk("multi_release_row", row_out, 4'b1101);

    // Reset during PRESSED, key (0,2) kept down throughout.
    wait_row(4'b1110);
    keys[2] = 1'b1;
    tick(4);
    chk("pre_rst_valid_cnt", vld_cnt, 3);
    chk("pre_rst_held", key_held, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_row", row_out, 4'b1110);
    chk("midrst_held", key_held, 1'b0);
    chk("midrst_code", key_code, 4'h0);
    release_rst();
    tick(3);
    chk("rerun_t3_valid", vld_cnt, 3);
    chk("rerun_t3_held", key_held, 1'b0);
    tick(1);
    chk("rerun_valid_cnt", vld_cnt, 4);
    chk("rerun_code", key_code, 4'h2);
    chk("rerun_held", key_held, 1'b1);
    keys = '0;
    tick(4);
    chk("rerun_release_held", key_held, 1'b0);

    // prd_in stuck high: no ticks, scan frozen; resumes once it moves again.
    wait_row(4'b1101);
    prd_hold = 1'b1;
    repeat (40) @(negedge clk);
    chk("stuck_row", row_out, 4'b1101);
    prd_hold = 1'b0;
    tick(1);
    chk("unstuck_row", row_out, 4'b1011);
    chk("final_valid_cnt", vld_cnt, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
